ascon_din_packer: RTL
=====================

ASCON_DIN_PACKER -- requirements
Module: ascon_din_packer

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock; the only clock in the block.
REQ-002 SHALL: rstn  input  1  asynchronous, active-low reset.
REQ-003 SHALL: s_valid  input  1  upstream byte valid.
REQ-004 SHALL: s_data  input  8  upstream byte; ignored when s_empty=1.
REQ-005 SHALL: s_type  input  1  segment type of the byte: 0 = AD, 1 = text.
REQ-006 SHALL: s_last  input  1  final item of the current segment.
REQ-007 SHALL: s_empty  input  1  item carries no byte; legal only with s_last=1; terminates the segment.
REQ-008 SHALL: s_ready  output  1  byte accepted on a cycle with s_valid & s_ready.
REQ-009 SHALL: start  output  1  one-cycle pulse to the Ascon core at message begin.
REQ-010 SHALL: Din  output  128  block to the core; first byte in Din[127:120].
REQ-011 SHALL: dinReq  output  1  block request to the core.
REQ-012 SHALL: dinAck  input  1  core acknowledge of Din.
REQ-013 SHALL: last_block  output  1  Din is the final, padded block of its segment.
REQ-014 SHALL: sel_data  output  1  segment of Din: 0 = AD, 1 = text.
REQ-015 SHALL: done  output  1  one-cycle pulse after the final text block is acknowledged.

Function
REQ-016 SHALL: implement states IDLE, START, FILL, PEND, GAP; a 5-bit byte count (0..16); a phase bit (AD, then TEXT); a pad_pending flag.
REQ-017 SHALL: in IDLE, hold s_ready=0; on s_valid with s_type=0, pulse start for one cycle and go to START.
REQ-018 SHALL: in START, go to FILL after one cycle with phase=AD and count=0.
REQ-019 SHALL: in FILL, drive s_ready=1 only when s_type equals the phase; an item with the wrong type stays pending and is not accepted.
REQ-020 SHALL: on an accepted data byte, write it into Din byte index count (bits 127-8*count downto 120-8*count), then increment count.
REQ-021 SHALL: when the 16th byte is accepted, go to PEND with last_block=0; set pad_pending=1 if that byte had s_last=1.
REQ-022 SHALL: on an accepted data byte with s_last=1 and resulting count n<16, write 0x80 at byte index n and zeros at indices n+1..15; set last_block=1; go to PEND.
REQ-023 SHALL: on an accepted s_empty item, write 0x80 at byte index count and zeros after it; set last_block=1; go to PEND (count 0 yields 0x8000...00).
REQ-024 SHALL: drive sel_data equal to the phase for every block.
REQ-025 SHALL: in PEND, hold dinReq=1 and hold Din, last_block and sel_data stable until dinAck is sampled 1, then take the action of exactly one of REQ-026 to REQ-028.
REQ-026 SHALL: on that dinAck with pad_pending=1: load Din=0x80 followed by zeros, set last_block=1, clear pad_pending, go to GAP.
REQ-027 SHALL: on that dinAck with last_block=1 and phase=AD: clear Din, set phase=TEXT, go to GAP.
REQ-028 SHALL: on that dinAck with last_block=1 and phase=TEXT: pulse done, set phase=AD, go to IDLE. On any other dinAck: clear Din and count and go to GAP.
REQ-029 SHALL: in GAP, drive dinReq=0 for exactly one cycle, then go to PEND if a pad block is loaded, else to FILL with count=0.
REQ-030 SHALL: hold s_ready=0 in START, PEND and GAP.
REQ-031 SHALL: ignore dinAck outside PEND.
REQ-032 SHALL: never assert start and dinReq in the same cycle.

Reset
REQ-033 SHALL: while rstn=0, immediately force dinReq=0, start=0, done=0, s_ready=0, last_block=0, sel_data=0, Din=0, count=0, pad_pending=0, phase=AD, state=IDLE, including mid-block and mid-handshake.
REQ-034 SHALL: after rstn deasserts, restart from IDLE; no partial block is resumed.

Verification
REQ-035 SHALL: AD bytes 00..0F (s_last on 0F), then text bytes 00..0F (s_last on 0F), dinAck echoes dinReq -> exactly one start pulse, then four blocks in order:
- 000102..0F, last=0, sel=0;
- 80 00..00, last=1, sel=0;
- 000102..0F, last=0, sel=1;
- 80 00..00, last=1, sel=1;
- then one done pulse.
REQ-036 SHALL: AD bytes AA BB CC (s_last on CC) -> Din=AABBCC80 00..00, last_block=1, sel_data=0.
REQ-037 SHALL: first item s_empty=1, s_last=1, s_type=0 -> one AD block 80 00..00 with last_block=1; then FILL with phase=TEXT.
REQ-038 SHALL: dinAck delayed 5 cycles -> dinReq, Din, last_block and sel_data constant for all 5 cycles; s_ready=0; exactly one block is consumed.
REQ-039 SHALL: text byte offered during phase AD -> not accepted (s_ready=0) until the AD last block is acknowledged; then accepted into byte index 0.
REQ-040 SHALL: rstn pulsed low while in PEND -> dinReq=0 and Din=0 without waiting for a clock edge; the next message starts with a fresh start pulse.

Source files
------------

// File: rtl/ascon_din_packer.sv
// Packs a byte stream (AD segment, then text segment) into 128-bit Ascon input
// blocks with 0x80 padding, and hands them to the core over a req/ack handshake.
module ascon_din_packer (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  input  logic [7:0]   s_data,
  input  logic         s_type,
  input  logic         s_last,
  input  logic         s_empty,
  output logic         s_ready,
  output logic         start,
  output logic [127:0] Din,
  output logic         dinReq,
  input  logic         dinAck,
  output logic         last_block,
  output logic         sel_data,
  output logic         done
);

  localparam int unsigned NBYTES = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DIN_W  = 128;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_PEND  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic PH_AD   = 1'b0;
  localparam logic PH_TEXT = 1'b1;

  localparam logic [DIN_W-1:0] PAD_BLOCK = {8'h80, 120'h0};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             phase_q, phase_d;
  logic             pad_pending_q, pad_pending_d;
  logic             pad_loaded_q, pad_loaded_d;
  logic [DIN_W-1:0] din_q, din_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  logic             accept;
  logic [CNT_W-1:0] count_inc;

  // Write byte b into byte lane idx (lane 0 is the most significant byte).
  function automatic logic [DIN_W-1:0] put_byte(logic [DIN_W-1:0] d,
                                                 logic [CNT_W-1:0] idx,
                                                 logic [7:0] b);
    logic [DIN_W-1:0] r;
    r = d;
    for (int i = 0; i < NBYTES; i++) begin
      if (CNT_W'(i) == idx) r[8*(NBYTES-1-i) +: 8] = b;
    end
    return r;
  endfunction

  // Place 0x80 at lane idx and clear every lane after it.
  function automatic logic [DIN_W-1:0] pad_from(logic [DIN_W-1:0] d,
                                                 logic [CNT_W-1:0] idx);
    logic [DIN_W-1:0] r;
    r = d;
    for (int i = 0; i < NBYTES; i++) begin
      if (CNT_W'(i) == idx)     r[8*(NBYTES-1-i) +: 8] = 8'h80;
      else if (CNT_W'(i) > idx) r[8*(NBYTES-1-i) +: 8] = 8'h00;
    end
    return r;
  endfunction

  assign s_ready    = (state_q == ST_FILL) && (s_type == phase_q);
  assign accept     = s_valid && s_ready;
  assign count_inc  = count_q + CNT_W'(1);
  assign start      = (state_q == ST_START);
  assign dinReq     = (state_q == ST_PEND);
  assign Din        = din_q;
  assign last_block = last_q;
  assign sel_data   = phase_q;
  assign done       = done_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      phase_q       <= PH_AD;
      pad_pending_q <= 1'b0;
      pad_loaded_q  <= 1'b0;
      din_q         <= '0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      phase_q       <= phase_d;
      pad_pending_q <= pad_pending_d;
      pad_loaded_q  <= pad_loaded_d;
      din_q         <= din_d;
      last_q        <= last_d;
      done_q        <= done_d;
    end
  end

  // Next-state and block assembly.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    phase_d       = phase_q;
    pad_pending_d = pad_pending_q;
    pad_loaded_d  = pad_loaded_q;
    din_d         = din_q;
    last_d        = last_q;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid && (s_type == PH_AD)) state_d = ST_START;
      end

      ST_START: begin
        state_d       = ST_FILL;
        phase_d       = PH_AD;
        count_d       = '0;
        last_d        = 1'b0;
        pad_pending_d = 1'b0;
        pad_loaded_d  = 1'b0;
      end

      ST_FILL: begin
        if (accept) begin
          if (s_empty) begin
            din_d   = pad_from(din_q, count_q);
            last_d  = 1'b1;
            state_d = ST_PEND;
          end else if (count_inc == CNT_W'(NBYTES)) begin
            // Full block; a final byte here needs a separate padding block.
            din_d         = put_byte(din_q, count_q, s_data);
            count_d       = count_inc;
            last_d        = 1'b0;
            pad_pending_d = s_last;
            state_d       = ST_PEND;
          end else if (s_last) begin
            din_d   = pad_from(put_byte(din_q, count_q, s_data), count_inc);
            count_d = count_inc;
            last_d  = 1'b1;
            state_d = ST_PEND;
          end else begin
            din_d   = put_byte(din_q, count_q, s_data);
            count_d = count_inc;
          end
        end
      end

      ST_PEND: begin
        if (dinAck) begin
          if (pad_pending_q) begin
            din_d         = PAD_BLOCK;
            last_d        = 1'b1;
            pad_pending_d = 1'b0;
            pad_loaded_d  = 1'b1;
            state_d       = ST_GAP;
          end else if (last_q && (phase_q == PH_AD)) begin
            din_d   = '0;
            count_d = '0;
            last_d  = 1'b0;
            phase_d = PH_TEXT;
            state_d = ST_GAP;
          end else if (last_q) begin
            din_d   = '0;
            count_d = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            phase_d = PH_AD;
            state_d = ST_IDLE;
          end else begin
            din_d   = '0;
            count_d = '0;
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (pad_loaded_q) begin
          pad_loaded_d = 1'b0;
          state_d      = ST_PEND;
        end else begin
          count_d = '0;
          last_d  = 1'b0;
          state_d = ST_FILL;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
